// File: rtl/pipeline_trace_tagger_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_trace_tagger_if
//  Description : Retire-trace record handshake bundle between the trace
//                tagger (master, producer) and the trace consumer (slave).
//                With TRACE_CYCLE_STAMP_EN defined, an extra trace_cycle
//                field carries the cycle stamp of each record.
//  Signals     : trace_valid  record available at FIFO head   (master out)
//                trace_ready  consumer accepts head record    (slave out)
//                trace_id     head record sequence ID         (master out)
//                trace_pc     head record PC                  (master out)
//                trace_halt   head record is HLT              (master out)
//                trace_cycle  head record cycle stamp         (master out,
//                             TRACE_CYCLE_STAMP_EN only)
//  Revision    : 1.0  initial release
// ============================================================================
interface pipeline_trace_tagger_if #(
    parameter int ID_W  = 8,
    parameter int PC_W  = 16,
    parameter int CYC_W = 32
);
    logic            trace_valid;
    logic            trace_ready;
    logic [ID_W-1:0] trace_id;
    logic [PC_W-1:0] trace_pc;
    logic            trace_halt;
`ifdef TRACE_CYCLE_STAMP_EN
    logic [CYC_W-1:0] trace_cycle;
`endif

    modport master (
        input  trace_ready,
        output trace_valid,
        output trace_id,
        output trace_pc,
`ifdef TRACE_CYCLE_STAMP_EN
        output trace_cycle,
`endif
        output trace_halt
    );

    modport slave (
        output trace_ready,
        input  trace_valid,
        input  trace_id,
        input  trace_pc,
`ifdef TRACE_CYCLE_STAMP_EN
        input  trace_cycle,
`endif
        input  trace_halt
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_trace_tagger.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_trace_tagger
//  Description : Tags each instruction latched into IF/ID with a sequence
//                ID, shadows {valid, id, pc, halt} through ID/EX/MEM/WB
//                (honouring stall and flush) and pushes one record per
//                retiring instruction into a record FIFO that is drained
//                over a valid/ready handshake.
//  Ports       : clk       system clock
//                rst_n     asynchronous active-low reset
//                if_pc     PC being fetched this cycle
//                if_hlt    fetched instruction is HLT
//                stall     hold IF/ID, inject bubble into EX
//                flush     squash instruction being latched into IF/ID
//                trace     record handshake (pipeline_trace_tagger_if.master)
//                overflow  sticky: a record was dropped on a full FIFO
//                halted    HLT has retired; tracing stopped
//  Option      : TRACE_CYCLE_STAMP_EN adds a free-running cycle counter and
//                a trace_cycle field holding the counter value at push time.
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_trace_tagger #(
    parameter int ID_W       = 8,
    parameter int PC_W       = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CYC_W      = 32
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic [PC_W-1:0]        if_pc,
    input  wire logic                   if_hlt,
    input  wire logic                   stall,
    input  wire logic                   flush,
    pipeline_trace_tagger_if.master     trace,
    output      logic                   overflow,
    output      logic                   halted
);

    localparam int c_addr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w  = c_addr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full_count = c_cnt_w'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_fetch_en;

    // Shadow pipeline stages
    logic [ID_W-1:0] r_next_id;
    logic            r_id_v,   r_ex_v,   r_mem_v,   r_wb_v;
    logic [ID_W-1:0] r_id_id,  r_ex_id,  r_mem_id,  r_wb_id;
    logic [PC_W-1:0] r_id_pc,  r_ex_pc,  r_mem_pc,  r_wb_pc;
    logic            r_id_hlt, r_ex_hlt, r_mem_hlt, r_wb_hlt;

    // Record FIFO
    logic [ID_W-1:0]     r_mem_q_id  [FIFO_DEPTH];
    logic [PC_W-1:0]     r_mem_q_pc  [FIFO_DEPTH];
    logic                r_mem_q_hlt [FIFO_DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic                r_overflow;
    logic                w_not_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_wr;

    assign w_fetch_en = (r_state == ST_RUN);

    // ------------------------------------------------------------------------
    // Halt-tracking FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_RUN: begin
                // In RUN fetch_en=1, so an unstalled, unflushed HLT latch is valid
                if (!stall && !flush && if_hlt) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_wb_v && r_wb_hlt) begin
                    w_state_nxt = ST_HALTED;
                end else if (stall && flush && r_id_v && r_id_hlt) begin
                    // Only a stalled flush destroys the ID entry; an unstalled
                    // flush lets the HLT advance into EX.
                    w_state_nxt = ST_RUN;
                end
            end
            ST_HALTED: begin
                w_state_nxt = ST_HALTED;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Shadow pipeline
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_next_id <= '0;
            r_id_v    <= 1'b0;  r_ex_v   <= 1'b0;  r_mem_v   <= 1'b0;  r_wb_v   <= 1'b0;
            r_id_id   <= '0;    r_ex_id  <= '0;    r_mem_id  <= '0;    r_wb_id  <= '0;
            r_id_pc   <= '0;    r_ex_pc  <= '0;    r_mem_pc  <= '0;    r_wb_pc  <= '0;
            r_id_hlt  <= 1'b0;  r_ex_hlt <= 1'b0;  r_mem_hlt <= 1'b0;  r_wb_hlt <= 1'b0;
        end else begin
            r_wb_v  <= r_mem_v;  r_wb_id  <= r_mem_id;  r_wb_pc  <= r_mem_pc;  r_wb_hlt  <= r_mem_hlt;
            r_mem_v <= r_ex_v;   r_mem_id <= r_ex_id;   r_mem_pc <= r_ex_pc;   r_mem_hlt <= r_ex_hlt;
            if (stall) begin
                r_ex_v <= 1'b0;
                if (flush) begin
                    r_id_v <= 1'b0;
                end
            end else begin
                r_ex_v <= r_id_v;  r_ex_id <= r_id_id;  r_ex_pc <= r_id_pc;  r_ex_hlt <= r_id_hlt;
                if (flush) begin
                    r_id_v <= 1'b0;
                end else begin
                    r_id_v    <= w_fetch_en;
                    r_id_id   <= r_next_id;
                    r_id_pc   <= if_pc;
                    r_id_hlt  <= if_hlt;
                    r_next_id <= r_next_id + ID_W'(w_fetch_en);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Record FIFO
    // ------------------------------------------------------------------------
    assign w_not_empty = (r_count != '0);
    assign w_full      = (r_count == c_full_count);
    assign w_push      = r_wb_v;
    assign w_pop       = w_not_empty && trace.trace_ready;
    // A push into a full FIFO still lands when the head leaves on the same edge
    assign w_wr        = w_push && (!w_full || w_pop);

`ifdef TRACE_CYCLE_STAMP_EN
    logic [CYC_W-1:0] r_cycle;
    logic [CYC_W-1:0] r_mem_q_cyc [FIFO_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + CYC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem_q_cyc[r_wr_ptr] <= r_cycle;
        end
    end

    assign trace.trace_cycle = w_not_empty ? r_mem_q_cyc[r_rd_ptr] : '0;
`endif

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem_q_id[r_wr_ptr]  <= r_wb_id;
            r_mem_q_pc[r_wr_ptr]  <= r_wb_pc;
            r_mem_q_hlt[r_wr_ptr] <= r_wb_hlt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
            end
            unique case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
            if (w_push && !w_wr) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Head fields are forced to zero while empty so reset shows clean outputs
    assign trace.trace_valid = w_not_empty;
    assign trace.trace_id    = w_not_empty ? r_mem_q_id[r_rd_ptr]  : '0;
    assign trace.trace_pc    = w_not_empty ? r_mem_q_pc[r_rd_ptr]  : '0;
    assign trace.trace_halt  = w_not_empty ? r_mem_q_hlt[r_rd_ptr] : 1'b0;

    assign overflow = r_overflow;
    assign halted   = (r_state == ST_HALTED);

endmodule
`default_nettype wire
